// File: rtl/score_text_pkg.sv
// score_text_pkg: ASCII label constants, converter FSM state enum, max_dec(digits) = 10^digits-1
package score_text_pkg;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [47:0] TXT_SCORE = "SCORE:";
  localparam logic [39:0] TXT_BEST = "BEST:";
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  function automatic logic [31:0] max_dec(input int digits);
    logic [31:0] p = 32'd1;
    for (int i = 0; i < digits; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble; clk, rst_n, start/bin_in load, bcd_out valid while done, busy when not idle
module bin2bcd_seq
  import score_text_pkg::*;
#(
  parameter int SCORE_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  done,
  output logic                  busy
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(SCORE_W + 1);
  conv_state_t state, state_nx;
  logic [SCORE_W-1:0] bin;
  logic [BW-1:0] bcd, adj;
  logic [CW-1:0] cnt;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CW'(SCORE_W - 1) ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        bin <= bin_in;
        bcd <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        {bcd, bin} <= {adj[BW-2:0], bin, 1'b0};
        cnt <= cnt + CW'(1);
      end
    end
  assign bcd_out = bcd;
  assign done = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: rtl/score_text_rom.sv
// score_text_rom: score overlay char generator; clk, rst_n, char_xy {row,col}, score_in, game_start, best_clr -> registered char_code, busy
module score_text_rom
  import score_text_pkg::*;
#(
  parameter int SCORE_W = 16,
  parameter int DIGITS = 5,
  parameter int BLANK_LZ = 1,
  parameter int DIGIT_COL = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         char_xy,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               game_start,
  input  logic               best_clr,
  output logic [7:0]         char_code,
  output logic               busy
);
  localparam int BW = 4 * DIGITS;
  localparam logic [63:0] MAXV = 64'(max_dec(DIGITS));
  if (DIGIT_COL + DIGITS > 16 || DIGITS < 1 || DIGITS > 8) begin : g_bad_cfg
    $error("score_text_rom: DIGITS must be 1..8 and DIGIT_COL+DIGITS <= 16");
  end
  logic [SCORE_W-1:0] best, last_s, last_b, conv_in;
  logic pend_s, pend_b, chan_b, start, load_s, load_b, conv_done, conv_busy, lz;
  logic [BW-1:0] bcd, disp_s, disp_b, disp;
  logic [3:0] row, col;
  logic [7:0] lut;
  function automatic logic [SCORE_W-1:0] clamp(input logic [SCORE_W-1:0] v);
    return 64'(v) > MAXV ? MAXV[SCORE_W-1:0] : v;
  endfunction
  assign start = !conv_busy && (pend_s || pend_b);
  assign load_s = start && pend_s;
  assign load_b = start && !pend_s;
  assign conv_in = clamp(pend_s ? score_in : best);
  assign busy = conv_busy || pend_s || pend_b;
  bin2bcd_seq #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_conv (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bin_in(conv_in),
    .bcd_out(bcd),
    .done(conv_done),
    .busy(conv_busy)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      best <= '0;
      last_s <= '0;
      last_b <= '0;
      pend_s <= 1'b0;
      pend_b <= 1'b0;
      chan_b <= 1'b0;
      disp_s <= '0;
      disp_b <= '0;
    end else begin
      best <= best_clr ? '0 : score_in > best ? score_in : best;
      pend_s <= !load_s && (pend_s || score_in != last_s);
      pend_b <= !load_b && (pend_b || best != last_b);
      if (load_s) last_s <= score_in;
      if (load_b) last_b <= best;
      if (start) chan_b <= load_b;
      if (conv_done && !chan_b) disp_s <= bcd;
      if (conv_done && chan_b) disp_b <= bcd;
    end
  assign row = char_xy[7:4];
  assign col = char_xy[3:0];
  always_comb begin
    disp = row[0] ? disp_b : disp_s;
    lut = row == 4'd0 && col < 4'd6 ? TXT_SCORE[8*(5-int'(col)) +: 8] :
          row == 4'd1 && col < 4'd5 ? TXT_BEST[8*(4-int'(col)) +: 8] : ASCII_SP;
    lz = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      lz = lz && disp[4*(DIGITS-1-i) +: 4] == 4'd0;
      if (row < 4'd2 && int'(col) == DIGIT_COL + i)
        lut = BLANK_LZ != 0 && lz && i != DIGITS - 1 ? ASCII_SP :
              ASCII_0 + {4'h0, disp[4*(DIGITS-1-i) +: 4]};
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) char_code <= ASCII_SP;
    else char_code <= game_start ? lut : ASCII_SP;
endmodule

// File: tb/tb_score_text_rom.sv
// tb_score_text_rom: randomized scoreboard bench for score_text_rom against a decimal-arithmetic reference model
module tb_score_text_rom;
  localparam int SW = 16;
  localparam int BIG = 1 << 30;
  typedef struct {int due; int dut; int kind; int exp; string nm;} ent_t;
  logic clk = 1'b0, rst_n = 1'b0, game_start = 1'b0, best_clr = 1'b0;
  logic [7:0] char_xy = 8'h00;
  logic [SW-1:0] score_in = '0;
  logic [7:0] code0, code1;
  logic busy0, busy1;
  int cyc = 0, vec = 0, miss = 0, act;
  ent_t sb[$];
  ent_t me;
  longint ds[2], db[2];
  longint sc = 0, bst = 0, v;
  bit clr;
  int c;

  score_text_rom u_dut0 (
    .clk(clk), .rst_n(rst_n), .char_xy(char_xy), .score_in(score_in),
    .game_start(game_start), .best_clr(best_clr), .char_code(code0), .busy(busy0)
  );
  score_text_rom #(.SCORE_W(SW), .DIGITS(4), .BLANK_LZ(0), .DIGIT_COL(10)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .char_xy(char_xy), .score_in(score_in),
    .game_start(game_start), .best_clr(best_clr), .char_code(code1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dg(int d); return d != 0 ? 4 : 5; endfunction
  function automatic int blk(int d); return d != 0 ? 0 : 1; endfunction
  function automatic int dcol(int d); return d != 0 ? 10 : 7; endfunction
  function automatic longint pw10(int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction
  function automatic longint clampv(int d, longint x);
    return x > pw10(dg(d)) - 1 ? pw10(dg(d)) - 1 : x;
  endfunction
  function automatic int ref_char(int d, int row, int col, bit gs, longint sv, longint bv);
    string s0 = "SCORE:";
    string s1 = "BEST:";
    longint x, p;
    int k;
    if (!gs || row > 1) return 32'h20;
    x = row != 0 ? bv : sv;
    k = col - dcol(d);
    if (k >= 0 && k < dg(d)) begin
      p = pw10(dg(d) - 1 - k);
      if (blk(d) != 0 && x < p && k != dg(d) - 1) return 32'h20;
      return 32'h30 + int'((x / p) % 10);
    end
    if (row == 0 && col < 6) return int'(s0[col]);
    if (row == 1 && col < 5) return int'(s1[col]);
    return 32'h20;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(int due, int d, int kind, int ex, string nm);
    ent_t e;
    e.due = due; e.dut = d; e.kind = kind; e.exp = ex; e.nm = nm;
    sb.push_back(e);
  endtask
  task automatic expb(bit b);
    for (int d = 0; d < 2; d++) push(cyc + 1, d, 1, int'(b), "busy");
  endtask
  task automatic probe(int row, int col, bit gs);
    char_xy = 8'(row * 16 + col);
    game_start = gs;
    for (int d = 0; d < 2; d++) push(cyc + 1, d, 0, ref_char(d, row, col, gs, ds[d], db[d]), "char");
    tick();
  endtask
  task automatic scan(int r0, int r1);
    for (int r = r0; r <= r1; r++)
      for (int cc = 0; cc < 16; cc++) probe(r, cc, 1'b1);
  endtask
  task automatic settle();
    repeat (3 * (SW + 2) + 4) tick();
    vec++;
    if (busy0 || busy1) begin
      miss++;
      $display("FAIL wait expired cyc=%0d: busy0=%0b busy1=%0b still high", cyc, busy0, busy1);
    end
    for (int d = 0; d < 2; d++) begin
      ds[d] = clampv(d, sc);
      db[d] = clampv(d, bst);
    end
    expb(1'b0);
    tick();
  endtask
  task automatic set_score(longint x);
    if (x != sc) expb(1'b1);
    score_in = SW'(x);
    sc = x;
    if (x > bst) bst = x;
  endtask
  task automatic trace(int n, longint s1, int t1, longint s2, int t2, longint b1, int tb, int chg, longint cv);
    for (int k = 0; k < n; k++) begin
      if (cyc == chg) begin
        score_in = SW'(cv);
        sc = cv;
        if (cv > bst) bst = cv;
      end
      for (int d = 0; d < 2; d++) begin
        if (cyc + 1 >= t1) ds[d] = clampv(d, s1);
        if (cyc + 1 >= t2) ds[d] = clampv(d, s2);
        if (cyc + 1 >= tb) db[d] = clampv(d, b1);
      end
      probe(k % 2, 7 + (k / 2) % 7, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      me = sb.pop_front();
      act = me.kind != 0 ? int'(me.dut != 0 ? busy1 : busy0) : int'(me.dut != 0 ? code1 : code0);
      vec++;
      if (me.due != cyc || act != me.exp) begin
        miss++;
        $display("FAIL %s dut%0d cyc=%0d due=%0d: got 'h%0h, expected 'h%0h", me.nm, me.dut, cyc, me.due, act, me.exp);
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin ds[d] = 0; db[d] = 0; end
    repeat (3) tick();
    vec++;
    if (code0 !== 8'h20 || code1 !== 8'h20 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
      miss++;
      $display("FAIL reset state: code0='h%0h code1='h%0h busy0=%0b busy1=%0b", code0, code1, busy0, busy1);
    end
    for (int d = 0; d < 2; d++) begin
      push(cyc, d, 0, 32'h20, "reset_char");
      push(cyc, d, 1, 0, "reset_busy");
    end
    tick();
    rst_n = 1'b1;
    game_start = 1'b1;
    expb(1'b0);
    for (int cc = 0; cc < 12; cc++) probe(0, cc, 1'b1);
    expb(1'b0);
    tick();
    c = cyc;
    set_score(12345);
    trace(46, 12345, c + SW + 4, 0, BIG, 12345, c + 2 * SW + 6, -1, 0);
    settle();
    scan(0, 1);
    c = cyc;
    set_score(100);
    trace(26, 100, c + SW + 4, 0, BIG, 12345, BIG, -1, 0);
    settle();
    c = cyc;
    set_score(20000);
    trace(62, 20000, c + SW + 4, 7, c + 2 * SW + 6, 20000, c + 3 * SW + 8, c + 5, 7);
    settle();
    scan(0, 1);
    set_score(65535);
    settle();
    scan(0, 1);
    set_score(0);
    settle();
    best_clr = 1'b1;
    bst = 0;
    tick();
    best_clr = 1'b0;
    settle();
    scan(1, 1);
    for (int j = 0; j < 8; j++) probe($urandom_range(0, 1), $urandom_range(7, 13), 1'b0);
    for (int it = 0; it < 12; it++) begin
      v = $urandom_range(0, 3) == 0 ? longint'($urandom_range(0, 99)) : longint'($urandom_range(0, 65535));
      clr = $urandom_range(0, 4) == 0;
      set_score(v);
      best_clr = clr;
      if (clr) bst = sc;
      tick();
      best_clr = 1'b0;
      settle();
      for (int j = 0; j < 10; j++)
        probe($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7) != 0);
      probe(0, 11, 1'b1);
      probe(1, 11, 1'b1);
    end
    char_xy = 8'h00;
    game_start = 1'b1;
    set_score(4321);
    repeat (6) tick();
    #1;
    rst_n = 1'b0;
    score_in = '0;
    for (int d = 0; d < 2; d++) begin
      push(cyc, d, 0, 32'h20, "async_rst_char");
      push(cyc, d, 1, 0, "async_rst_busy");
    end
    tick();
    tick();
    rst_n = 1'b1;
    sc = 0;
    bst = 0;
    for (int d = 0; d < 2; d++) begin ds[d] = 0; db[d] = 0; end
    for (int j = 0; j < 6; j++) begin
      expb(1'b0);
      probe(j % 2, 7 + j, 1'b1);
    end
    scan(0, 1);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
